// File: rtl/sound_mixer_n.sv
// Multi-channel square-wave tone generator and saturating mixer.
// Optional linear attack/release envelope per channel: define SOUND_MIXER_ENVELOPE_EN.
module sound_mixer_n #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16,
  parameter int VOL_WIDTH = 4,
  parameter int GAIN      = 8,
  parameter int ENV_STEP  = 256
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [CHANNELS-1:0]                               switches,
  input  logic                                              cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_sel,
  input  logic                                              cfg_is_vol,
  input  logic [DIV_WIDTH-1:0]                              cfg_data,
  output logic [WIDTH-1:0]                                  combined,
  output logic                                              clip
);

  localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SUM_W  = VOL_WIDTH + SEL_W + 1;
  localparam int GAIN_W = $clog2(GAIN + 1) + 1;
  localparam int MW     = SUM_W + GAIN_W + WIDTH;
  localparam logic [MW-1:0] MAX_M = {{(MW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  logic                                sel_ok;
  logic [CHANNELS-1:0][VOL_WIDTH-1:0]  amp;
  logic [SUM_W-1:0]                    sum;
  logic [MW-1:0]                       m;
  logic                                sat;

  assign sel_ok = cfg_we && ({1'b0, cfg_sel} < (SEL_W+1)'(CHANNELS));

`ifdef SOUND_MIXER_ENVELOPE_EN
  localparam int PRE_W = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;

  logic [PRE_W-1:0] pre;
  logic             env_tick;

  assign env_tick = (pre == PRE_W'(ENV_STEP - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      pre <= '0;
    else if (env_tick)
      pre <= '0;
    else
      pre <= pre + PRE_W'(1);
  end
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] period;
    logic [DIV_WIDTH-1:0] cnt;
    logic [VOL_WIDTH-1:0] vol;
    logic                 phase;
    logic                 run;
    logic                 wr_p;
    logic                 wr_v;

    assign wr_p = sel_ok && !cfg_is_vol && (cfg_sel == SEL_W'(i));
    assign wr_v = sel_ok &&  cfg_is_vol && (cfg_sel == SEL_W'(i));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        period <= '0;
        vol    <= '1;
      end else if (wr_p) begin
        period <= cfg_data;
      end else if (wr_v) begin
        vol    <= cfg_data[VOL_WIDTH-1:0];
      end
    end

`ifdef SOUND_MIXER_ENVELOPE_EN
    logic [VOL_WIDTH-1:0] env;
    logic [VOL_WIDTH-1:0] target;

    assign target = switches[i] ? vol : '0;

    // Level slews one step per prescaler wrap, so attack, release and volume drops share one rate.
    always_ff @(posedge clk) begin
      if (!rst_n)
        env <= '0;
      else if (env_tick && (env < target))
        env <= env + VOL_WIDTH'(1);
      else if (env_tick && (env > target))
        env <= env - VOL_WIDTH'(1);
    end

    assign run    = (switches[i] || (env != '0)) && (period != '0);
    assign amp[i] = (run && phase) ? env : '0;
`else
    assign run    = switches[i] && (period != '0);
    assign amp[i] = (run && phase) ? vol : '0;
`endif

    // A period write restarts the half-period but keeps the current phase level.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (!run) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (wr_p) begin
        cnt   <= '0;
      end else if (cnt == (period - DIV_WIDTH'(1))) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt   <= cnt + DIV_WIDTH'(1);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++)
      sum = sum + SUM_W'(amp[i]);
  end

  assign m   = MW'(sum) * MW'(GAIN);
  assign sat = (m > MAX_M);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      combined <= '0;
      clip     <= 1'b0;
    end else begin
      combined <= sat ? {WIDTH{1'b1}} : m[WIDTH-1:0];
      clip     <= sat;
    end
  end

endmodule
